pipe_stage_reg: RTL and testbench

Parametrised pipeline segment register with a valid/ready handshake, stall, flush and bubble insertion. It generalises the fixed per-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. Each stage instantiates it with its own packed payload. Control bits that must never leak from a bubble (register write-enable, memory enables, HI/LO writes) travel on a separate gated bus.

---
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Purpose: one generic pipeline segment register with a valid/ready handshake, flush, bubble gating and a stall counter.
// Latency: 1 cycle from input transfer to out_*. Optional 2-entry skid buffer under `PIPE_SKID_EN`.
// Backpressure: without skid, in_ready = !main_valid || out_ready (combinational); with skid, in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int DATA_W   = 128,
  parameter int CTRL_W   = 16,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  // A flushed cycle never accepts the offered entry, whatever in_ready says.
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  // Side-effect controls must never leak out of a bubble, even if the register is stale.
  assign out_ctrl  = main_valid ? main_ctrl : '0;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Ready depends only on skid occupancy, so out_ready has no combinational path upstream.
  assign in_ready = !skid_valid;

  // Main/skid register update: flush first, then drain skid into main, then normal load/unload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      if (CLR_DATA) main_data <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (out_xfer && skid_valid) begin
      // in_ready is low while skid is full, so no new entry can arrive this cycle.
      main_data  <= skid_data;
      main_ctrl  <= skid_ctrl;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (out_xfer) begin
      if (in_xfer) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
        if (CLR_DATA) main_data <= '0;
      end
    end else if (in_xfer) begin
      if (main_valid) begin
        // Main is stalled: park the new entry behind it to keep FIFO order.
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
      end else begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
      end
    end
  end
`else
  // A full, stalled stage pushes back upstream in the same cycle.
  assign in_ready = !main_valid || out_ready;

  // Main register update: flush wins, then load, then unload to a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      if (CLR_DATA) main_data <= '0;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
      main_ctrl  <= in_ctrl;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      if (CLR_DATA) main_data <= '0;
    end
  end
`endif

  // Saturating count of cycles where downstream refused a valid entry; flush leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, bubble gating, stall, flush, async reset, saturation.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
// Builds with or without PIPE_SKID_EN; the stall scenario adapts its in_ready expectations.
module tb_pipe_stage_reg;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [15:0]  in_ctrl;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_ctrl;
  logic [15:0]  stall_cnt;

  int checks;
  int failures;

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .CLR_DATA(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'd0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (out_ctrl !== 16'd0) begin failures++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    resetn = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 128'(i); in_ctrl = 16'(i * 16'h0101);
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== 128'(i)) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, out_data, i); end
      checks++; if (out_ctrl !== 16'(i * 16'h0101)) begin failures++; $display("FAIL stream_ctrl[%0d] got=%0h exp=%0h", i, out_ctrl, i * 16'h0101); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'd0) begin failures++; $display("FAIL stream_drain_data got=%0h exp=0", out_data); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_bubble();
    in_valid = 1'b0; in_ctrl = 16'hFFFF; in_data = 128'hDEAD; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_ctrl !== 16'd0) begin failures++; $display("FAIL bubble_ctrl[%0d] got=%0h exp=0", i, out_ctrl); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_stall();
    logic exp_rdy;
    in_valid = 1'b1; in_data = 128'd5; in_ctrl = 16'h0005; out_ready = 1'b0;
    step();
    checks++; if (out_data !== 128'd5) begin failures++; $display("FAIL stall_load got=%0h exp=5", out_data); end
    in_data = 128'd6; in_ctrl = 16'h0006;
`ifdef PIPE_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL stall_first_ready got=%b exp=%b", in_ready, exp_rdy); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (out_data !== 128'd5) begin failures++; $display("FAIL stall_hold[%0d] got=%0h exp=5", i, out_data); end
      checks++; if (stall_cnt !== 16'(i)) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, i); end
      if (i < 3) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_ready); end
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 128'd6) begin failures++; $display("FAIL stall_release_data got=%0h exp=6", out_data); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_release_valid got=%b exp=1", out_valid); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL stall_release_cnt got=%0d exp=3", stall_cnt); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 128'hAB; in_ctrl = 16'h00FF; out_ready = 1'b0;
    step();
    checks++; if (out_ctrl !== 16'h00FF) begin failures++; $display("FAIL flush_pre_ctrl got=%0h exp=00ff", out_ctrl); end
    flush = 1'b1; in_valid = 1'b1; in_data = 128'hCD; in_ctrl = 16'h1234;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 16'd0) begin failures++; $display("FAIL flush_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (out_data !== 128'd0) begin failures++; $display("FAIL flush_data got=%0h exp=0", out_data); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd4) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 128'h77; in_ctrl = 16'h0003; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b exp=1", out_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'd0) begin failures++; $display("FAIL arst_data got=%0h exp=0", out_data); end
    checks++; if (out_ctrl !== 16'd0) begin failures++; $display("FAIL arst_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL arst_stall_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    resetn = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_data = 128'h99; in_ctrl = 16'h0001; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_before got=%0h exp=fffe", stall_cnt); end
    step();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%0h exp=ffff", stall_cnt); end
    for (int i = 0; i < 4465; i++) @(posedge clk);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
    checks++; if (out_data !== 128'h99) begin failures++; $display("FAIL sat_data got=%0h exp=99", out_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_bubble();
    test_stall();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
